// File: rtl/uart_receiver.sv
// UART receive path: 16x oversampled, centre-sampled, LSB-first frame decoder.
// Delivers each word with a one-cycle rx_done strobe and flags a low stop bit.
module uart_receiver #(
  parameter int DATA_BITS = 3,
  parameter int SB_TICK   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 frame_err
);

  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [3:0]           s_cnt_q, s_cnt_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_q         <= n_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    n_d         = n_q;
    b_d         = b_q;
    dout_d      = dout_q;
    rx_done_d   = 1'b0;
    frame_err_d = frame_err_q;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (tick) begin
          if (s_cnt_q == 4'd7) begin
            s_cnt_d = '0;
            if (!rx_s_q) begin
              state_d = DATA;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_cnt_q == 4'd15) begin
            s_cnt_d = '0;
            // Shift in from the top so the first (LSB) bit ends at b[0].
            b_d = (b_q >> 1) | (DATA_BITS'(rx_s_q) << (DATA_BITS - 1));
            if (n_q == NW'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (s_cnt_q == 4'(SB_TICK - 1)) begin
            state_d     = IDLE;
            s_cnt_d     = '0;
            dout_d      = b_q;
            frame_err_d = ~rx_s_q;
            rx_done_d   = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dout      = dout_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames driven bit-by-bit on a 1-in-17 tick,
// completions captured on the falling edge and compared with hand-derived values.
module tb_uart_receiver;

  localparam int DB = 3;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic          tick = 1'b0;
  logic          rx   = 1'b1;
  logic [DB-1:0] dout;
  logic          rx_done;
  logic          frame_err;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int unsigned tick_div = 0;
  int unsigned tick_total = 0;
  int          done_cnt = 0;
  int          run_len = 0;
  int          max_run = 0;
  logic [DB-1:0] cap_dout[$];
  logic          cap_fe[$];
  int unsigned   cap_tick[$];

  uart_receiver #(.DATA_BITS(DB), .SB_TICK(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .rx       (rx),
    .dout     (dout),
    .rx_done  (rx_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // One tick every 17 clocks; tick_total counts ticks the DUT has seen.
  always @(posedge clk) begin
    tick_div <= (tick_div == 16) ? 0 : tick_div + 1;
    tick     <= (tick_div == 16);
    if (tick) tick_total <= tick_total + 1;
  end

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      cap_dout.push_back(dout);
      cap_fe.push_back(frame_err);
      cap_tick.push_back(tick_total);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns #1 after the n-th tick edge so driven inputs never race the DUT.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int stop_ticks);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop;
    wait_ticks(stop_ticks);
    rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int unsigned st;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_done", rx_done, 0);
    check("rst_fe", frame_err, 0);
    rst = 1'b1;
    wait_ticks(2);

    // Single frame: 5, nominal 72-tick latency.
    base = done_cnt;
    st   = tick_total;
    send_frame(3'd5, 1'b1, 16);
    check("single_cnt", done_cnt - base, 1);
    check("single_dout", cap_dout[base], 5);
    check("single_fe", cap_fe[base], 0);
    check("single_lat", cap_tick[base] - st, 72);

    // Back-to-back: second start edge right after the stop-bit sample.
    wait_ticks(3);
    base = done_cnt;
    send_frame(3'd2, 1'b1, 8);
    send_frame(3'd7, 1'b1, 16);
    check("b2b_cnt", done_cnt - base, 2);
    check("b2b_dout0", cap_dout[base], 2);
    check("b2b_dout1", cap_dout[base+1], 7);
    check("b2b_fe0", cap_fe[base], 0);
    check("b2b_fe1", cap_fe[base+1], 0);
    check("b2b_gap", cap_tick[base+1] - cap_tick[base], 72);

    // False start: 4 ticks low then high.
    wait_ticks(4);
    base = done_cnt;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(12);
    check("false_cnt", done_cnt - base, 0);
    send_frame(3'd3, 1'b1, 16);
    check("false_after_cnt", done_cnt - base, 1);
    check("false_after_dout", cap_dout[base], 3);

    // Framing error: stop held low through its sample point only.
    wait_ticks(3);
    base = done_cnt;
    send_frame(3'd6, 1'b0, 8);
    wait_ticks(12);
    check("ferr_cnt", done_cnt - base, 1);
    check("ferr_dout", cap_dout[base], 6);
    check("ferr_fe", cap_fe[base], 1);
    check("ferr_hold", frame_err, 1);
    send_frame(3'd1, 1'b1, 16);
    check("ferr_next_dout", cap_dout[base+1], 1);
    check("ferr_next_fe", cap_fe[base+1], 0);

    // Reset in the middle of data bit 1 of frame 4.
    wait_ticks(3);
    base = done_cnt;
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(8);
    rst = 1'b0;
    #1;
    check("mrst_dout", dout, 0);
    check("mrst_done", rx_done, 0);
    check("mrst_fe", frame_err, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_ticks(20);
    check("mrst_cnt", done_cnt - base, 0);
    send_frame(3'd5, 1'b1, 16);
    check("mrst_after_cnt", done_cnt - base, 1);
    check("mrst_after_dout", cap_dout[base], 5);

    // Loopback-style sweep: full frames back to back, 0..7.
    wait_ticks(3);
    base = done_cnt;
    for (int d = 0; d < 8; d++) send_frame(DB'(d), 1'b1, 16);
    wait_ticks(2);
    check("loop_cnt", done_cnt - base, 8);
    for (int d = 0; d < 8; d++) begin
      if (base + d < done_cnt) begin
        check($sformatf("loop_dout%0d", d), cap_dout[base+d], d);
        check($sformatf("loop_fe%0d", d), cap_fe[base+d], 0);
      end
    end

    check("done_width", max_run, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receiver for the UART system. It is the receive-side counterpart of the existing transmitter and uses the same frame format, tick source and data width: 1 start bit (low), `DATA_BITS` data bits LSB first, and 1 stop bit (high). It oversamples the `rx` line 16× on the shared baud `tick` and samples each bit at its centre. It presents each received word on `dout` with a one-cycle `rx_done` strobe and reports a bad stop bit on `frame_err`.

## Interface
- `DATA_BITS`, default 3: data bits per frame; matches the transmitter `din` width.
- `SB_TICK`, default 16: ticks counted in the stop bit before it is sampled (16 = stop-bit centre).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `tick`  in  1  oversampling strobe at 16× baud; single-cycle pulse; shared with the transmitter.
- `rx`  in  1  serial line. Idle high. Asynchronous to `clk`.
- `dout`  out  DATA_BITS  last received word. Holds until the next `rx_done`.
- `rx_done`  out  1  one-cycle pulse when a frame completes (stop bit sampled).
- `frame_err`  out  1  stop-bit value of the last completed frame was 0. Updated with `rx_done` and held.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer that resets to 1. All decisions use the synchronized value `rx_s`.
- **Registers.**
  - state
  - 4-bit tick counter `s_cnt`
  - bit counter `n`, width `$clog2(DATA_BITS)`, minimum 1
  - shift register `b[DATA_BITS-1:0]`
  - `dout`, `rx_done`, `frame_err`
- **IDLE**
  - `rx_s==0` → START, `s_cnt=0`. `tick` is not required for this transition.
- **START** (changes only on cycles with `tick=1`)
  - `s_cnt==7`:
    - `rx_s==0` → DATA, `s_cnt=0`, `n=0`.
    - `rx_s==1` → IDLE. This is a false start (glitch): no `rx_done` and no output change.
  - Otherwise `s_cnt++`.
- **DATA** (on `tick`)
  - `s_cnt==15`: `s_cnt=0` and `b = {rx_s, b[DATA_BITS-1:1]}` (LSB first).
    - If `n==DATA_BITS-1` → STOP.
    - Otherwise `n++`.
  - Otherwise `s_cnt++`.
- **STOP** (on `tick`)
  - `s_cnt==SB_TICK-1`: `dout<=b`, `frame_err<=~rx_s`, `rx_done<=1`, → IDLE, `s_cnt=0`.
  - Otherwise `s_cnt++`.
- **Framing error.** A frame with a bad stop bit is still delivered: `dout` is updated and `rx_done` pulses, with `frame_err=1`. The receiver does not wait for the line to return high; a low `rx_s` in IDLE starts a new frame.
- **Strobe rules.** `rx_done` is forced to 0 on every cycle other than the completion cycle. `s_cnt` wraps only through the explicit compares; it never free-runs past 15.
- **Tick during IDLE.** A `tick` in IDLE has no effect.

## Timing
- **Reset values:**
  - state=IDLE, `s_cnt=0`, `n=0`, `b=0`
  - `dout=0`, `rx_done=0`, `frame_err=0`
  - synchronizer flops=1
- **Reset mid-frame:** immediate return to IDLE with the values above. A partial frame is discarded and no `rx_done` is produced.
- **Synchronizer latency:** 2 `clk` cycles from an `rx` edge to `rx_s`.
- **Sample points**, counted in ticks after IDLE→START:
  - start-bit check on the 8th tick
  - data bit k sampled 16 ticks after the previous sample (bit centres)
  - stop bit sampled `SB_TICK` ticks after the last data sample
- **Frame duration:** nominal 8 + 16·DATA_BITS + SB_TICK ticks from the start edge to `rx_done`; 72 ticks with defaults.
- **`rx_done` timing:** asserted in the `clk` cycle after the completing tick edge, high for exactly 1 cycle. `dout` and `frame_err` are valid in that same cycle.
- **Back-to-back frames:** a start edge arriving in the cycle after STOP→IDLE is accepted. The minimum inter-frame gap is 0 ticks beyond the half stop bit still remaining.
- **Tick spacing:** ≥2 `clk` cycles between `tick` pulses is required. A tick on consecutive cycles is still counted, once per cycle.

## Test plan
- **Single frame.** Tick every 17 clk. Drive a frame of `din=3'd5` (bits 1,0,1 LSB first), stop=1 → one `rx_done` pulse, `dout=3'd5`, `frame_err=0`, `rx_done` high for exactly 1 cycle.
- **Back-to-back frames.** Frames `3'd2` then `3'd7` with no idle gap → two `rx_done` pulses 64–72 ticks apart, `dout` = 2 then 7, `frame_err=0` both times.
- **False start.** `rx` low for 4 ticks then high → no `rx_done`, state back to IDLE by tick 8. A valid `3'd3` frame sent afterwards is received correctly.
- **Framing error.** Frame `3'd6` with stop bit driven 0 → `rx_done` pulses, `dout=3'd6`, `frame_err=1`. A following good frame `3'd1` gives `frame_err=0`.
- **Reset mid-frame.** Assert `rst=0` during data bit 1 of frame `3'd4` → all outputs 0 immediately, no `rx_done`. After release, frame `3'd5` gives `dout=5`.
- **Loopback.** Transmitter `tx` → receiver `rx` on a shared tick. Sweep `din` 0..7 with `tx_start` after each `tx_done` → each word is received, `dout==din`, `frame_err=0`, 8 `rx_done` pulses in total.
